// File: rtl/ycr1_imem_arb_pkg.sv
// Shared memory-interface definitions for the instruction-memory arbiter:
// command/response encodings, default bus widths and a port helper.
package ycr1_imem_arb_pkg;

  localparam int YCR1_IMEM_AWIDTH_DFLT = 32;
  localparam int YCR1_IMEM_DWIDTH_DFLT = 32;

  typedef enum logic {
    YCR1_MEM_CMD_RD = 1'b0,
    YCR1_MEM_CMD_WR = 1'b1
  } ycr1_mem_cmd_e;

  typedef enum logic [1:0] {
    YCR1_MEM_RESP_NOTRDY = 2'b00,
    YCR1_MEM_RESP_RDY_OK = 2'b01,
    YCR1_MEM_RESP_RDY_ER = 2'b10
  } ycr1_mem_resp_e;

  function automatic logic [1:0] ycr1_port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ycr1_arb_rr2.sv
// Two-port grant selector: round-robin or fixed priority, with a lock that
// keeps a presented-but-unacked selection stable until ack or req drop.
module ycr1_arb_rr2
  import ycr1_imem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       valid,
  input  logic       advance,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  logic last_q;
  logic lock_q;
  logic lock_port_q;

  always_comb begin
    grant = 2'b00;
    if (fixed_prio) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else if (lock_q && req[lock_port_q]) begin
      grant = ycr1_port_onehot(lock_port_q);
    end else if (&req) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // last_q = 1 means port 1 was granted last, so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      lock_port_q <= 1'b0;
    end else if (advance) begin
      last_q <= grant[1];
      lock_q <= 1'b0;
    end else if (valid && !fixed_prio && (|grant)) begin
      lock_q      <= 1'b1;
      lock_port_q <= grant[1];
    end else if (lock_q && !req[lock_port_q]) begin
      lock_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ycr1_imem_arb.sv
// Two-requester instruction-memory arbiter with at most one outstanding
// transaction; commands and responses pass through with zero added latency.
module ycr1_imem_arb
  import ycr1_imem_arb_pkg::*;
#(
  parameter int YCR1_ARB_FIXED_PRIO = 0,
  parameter int YCR1_IMEM_AWIDTH    = YCR1_IMEM_AWIDTH_DFLT,
  parameter int YCR1_IMEM_DWIDTH    = YCR1_IMEM_DWIDTH_DFLT
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        req0_req,
  input  logic                        req0_cmd,
  input  logic [YCR1_IMEM_AWIDTH-1:0] req0_addr,
  output logic                        req0_req_ack,
  output logic [YCR1_IMEM_DWIDTH-1:0] req0_rdata,
  output logic [1:0]                  req0_resp,

  input  logic                        req1_req,
  input  logic                        req1_cmd,
  input  logic [YCR1_IMEM_AWIDTH-1:0] req1_addr,
  output logic                        req1_req_ack,
  output logic [YCR1_IMEM_DWIDTH-1:0] req1_rdata,
  output logic [1:0]                  req1_resp,

  output logic                        mem_req,
  output logic                        mem_cmd,
  output logic [YCR1_IMEM_AWIDTH-1:0] mem_addr,
  input  logic                        mem_req_ack,
  input  logic [YCR1_IMEM_DWIDTH-1:0] mem_rdata,
  input  logic [1:0]                  mem_resp
);

  // state    | meaning
  // ARB_IDLE | nothing outstanding, grant window open
  // ARB_DATA | one transaction outstanding for owner_q, waiting on mem_resp
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_DATA = 1'b1
  } arb_state_e;

  localparam logic FIXED_PRIO = (YCR1_ARB_FIXED_PRIO != 0);

  arb_state_e fsm_q;
  logic       owner_q;
  logic [1:0] grant;
  logic       window_open;
  logic       handshake;
  logic       resp_ok;
  logic       resp_er;

  assign resp_ok = (mem_resp == YCR1_MEM_RESP_RDY_OK);
  assign resp_er = (mem_resp == YCR1_MEM_RESP_RDY_ER);

  // rst_n gates the window so no command escapes while reset is held
  assign window_open = rst_n & ((fsm_q == ARB_IDLE) | ((fsm_q == ARB_DATA) & resp_ok));

  assign mem_req   = window_open & (|grant);
  assign mem_cmd   = grant[1] ? req1_cmd  : req0_cmd;
  assign mem_addr  = grant[1] ? req1_addr : req0_addr;
  assign handshake = mem_req & mem_req_ack;

  assign req0_req_ack = mem_req & grant[0] & mem_req_ack;
  assign req1_req_ack = mem_req & grant[1] & mem_req_ack;

  ycr1_arb_rr2 u_rr2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        ({req1_req, req0_req}),
    .valid      (mem_req),
    .advance    (handshake),
    .fixed_prio (FIXED_PRIO),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ARB_IDLE;
      owner_q <= 1'b0;
    end else begin
      case (fsm_q)
        ARB_IDLE: begin
          if (handshake) begin
            fsm_q   <= ARB_DATA;
            owner_q <= grant[1];
          end
        end
        ARB_DATA: begin
          if (resp_ok) begin
            if (handshake) owner_q <= grant[1];
            else           fsm_q   <= ARB_IDLE;
          end else if (resp_er) begin
            fsm_q <= ARB_IDLE;
          end
        end
        default: fsm_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    req0_resp  = YCR1_MEM_RESP_NOTRDY;
    req1_resp  = YCR1_MEM_RESP_NOTRDY;
    req0_rdata = '0;
    req1_rdata = '0;
    if (fsm_q == ARB_DATA) begin
      if (owner_q) begin
        req1_resp  = mem_resp;
        req1_rdata = mem_rdata;
      end else begin
        req0_resp  = mem_resp;
        req0_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ycr1_imem_arb.sv
// Scoreboard bench for ycr1_imem_arb: directed per-cycle stimulus pushes
// expected acks/responses; a negedge monitor pops and compares them.
module tb_ycr1_imem_arb;
  import ycr1_imem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] A0 = 32'h0001_0000;
  localparam logic [AW-1:0] A1 = 32'h0002_0040;
  localparam logic [1:0] NR = 2'b00;
  localparam logic [1:0] OK = 2'b01;
  localparam logic [1:0] ER = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_req = 1'b0, req1_req = 1'b0;
  logic req0_cmd, req1_cmd;
  logic [AW-1:0] req0_addr, req1_addr;
  logic mem_req_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0] mem_resp = 2'b00;

  logic [1:0]    ack0_d, ack1_d, mem_req_d, mem_cmd_d;
  logic [DW-1:0] rdata0_d [2];
  logic [DW-1:0] rdata1_d [2];
  logic [1:0]    resp0_d [2];
  logic [1:0]    resp1_d [2];
  logic [AW-1:0] mem_addr_d [2];

  int sel = 0;
  int cyc_n = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    int         port;
    bit         is_resp;
    logic [1:0] code;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  always #5 clk = ~clk;

  ycr1_imem_arb #(.YCR1_ARB_FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_req(req0_req), .req0_cmd(req0_cmd), .req0_addr(req0_addr),
    .req0_req_ack(ack0_d[0]), .req0_rdata(rdata0_d[0]), .req0_resp(resp0_d[0]),
    .req1_req(req1_req), .req1_cmd(req1_cmd), .req1_addr(req1_addr),
    .req1_req_ack(ack1_d[0]), .req1_rdata(rdata1_d[0]), .req1_resp(resp1_d[0]),
    .mem_req(mem_req_d[0]), .mem_cmd(mem_cmd_d[0]), .mem_addr(mem_addr_d[0]),
    .mem_req_ack(mem_req_ack), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  ycr1_imem_arb #(.YCR1_ARB_FIXED_PRIO(1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_req(req0_req), .req0_cmd(req0_cmd), .req0_addr(req0_addr),
    .req0_req_ack(ack0_d[1]), .req0_rdata(rdata0_d[1]), .req0_resp(resp0_d[1]),
    .req1_req(req1_req), .req1_cmd(req1_cmd), .req1_addr(req1_addr),
    .req1_req_ack(ack1_d[1]), .req1_rdata(rdata1_d[1]), .req1_resp(resp1_d[1]),
    .mem_req(mem_req_d[1]), .mem_cmd(mem_cmd_d[1]), .mem_addr(mem_addr_d[1]),
    .mem_req_ack(mem_req_ack), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic push_ack(input int port);
    ev_t e;
    e.cyc = cyc_n; e.port = port; e.is_resp = 1'b0;
    e.code = (port == 1) ? {1'b0, YCR1_MEM_CMD_WR} : {1'b0, YCR1_MEM_CMD_RD};
    e.data = (port == 1) ? A1 : A0;
    exp_q.push_back(e);
  endtask

  task automatic push_resp(input int port, input logic [1:0] code, input logic [31:0] data);
    ev_t e;
    e.cyc = cyc_n; e.port = port; e.is_resp = 1'b1; e.code = code; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic mack,
                       input logic [1:0] mresp, input logic [31:0] mdata);
    @(posedge clk);
    #1;
    req0_req = r0; req1_req = r1; mem_req_ack = mack;
    mem_resp = mresp; mem_rdata = mdata;
    cyc_n++;
  endtask

  task automatic check_reset_vals();
    for (int d = 0; d < 2; d++) begin
      chk("rst_mem_req", {31'd0, mem_req_d[d]}, 32'd0);
      chk("rst_ack0",    {31'd0, ack0_d[d]},    32'd0);
      chk("rst_ack1",    {31'd0, ack1_d[d]},    32'd0);
      chk("rst_resp0",   {30'd0, resp0_d[d]},   32'd0);
      chk("rst_resp1",   {30'd0, resp1_d[d]},   32'd0);
      chk("rst_rdata0",  rdata0_d[d],           32'd0);
      chk("rst_rdata1",  rdata1_d[d],           32'd0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0_req = 1'b0; req1_req = 1'b0; mem_req_ack = 1'b0;
    mem_resp = NR; mem_rdata = '0;
    #2;
    check_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // monitor: collect what the selected DUT presents, in fixed order
  always @(negedge clk) begin
    ev_t o;
    ev_t e;
    obs_q.delete();
    for (int p = 0; p < 2; p++) begin
      if ((p == 0) ? ack0_d[sel] : ack1_d[sel]) begin
        o.cyc = cyc_n; o.port = p; o.is_resp = 1'b0;
        o.code = {1'b0, mem_cmd_d[sel]}; o.data = mem_addr_d[sel];
        obs_q.push_back(o);
      end
    end
    for (int p = 0; p < 2; p++) begin
      o.cyc = cyc_n; o.port = p; o.is_resp = 1'b1;
      o.code = (p == 0) ? resp0_d[sel] : resp1_d[sel];
      o.data = (p == 0) ? rdata0_d[sel] : rdata1_d[sel];
      if (o.code != NR) begin
        obs_q.push_back(o);
      end else begin
        n_tests++;
        if (o.data !== '0) begin
          n_fail++;
          $display("FAIL idle_rdata p%0d: got %h, expected 0 (cycle %0d)", p, o.data, cyc_n);
        end
      end
    end
    foreach (obs_q[i]) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected p%0d resp=%0d: got code %0d data %h, expected nothing (cycle %0d)",
                 obs_q[i].port, obs_q[i].is_resp, obs_q[i].code, obs_q[i].data, cyc_n);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != obs_q[i].cyc || e.port != obs_q[i].port || e.is_resp != obs_q[i].is_resp ||
            e.code !== obs_q[i].code || e.data !== obs_q[i].data) begin
          n_fail++;
          $display("FAIL scoreboard: got cyc %0d p%0d resp=%0d code %0d data %h, expected cyc %0d p%0d resp=%0d code %0d data %h",
                   obs_q[i].cyc, obs_q[i].port, obs_q[i].is_resp, obs_q[i].code, obs_q[i].data,
                   e.cyc, e.port, e.is_resp, e.code, e.data);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing: got nothing, expected cyc %0d p%0d resp=%0d code %0d data %h",
               e.cyc, e.port, e.is_resp, e.code, e.data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_cmd = YCR1_MEM_CMD_RD; req0_addr = A0;
    req1_cmd = YCR1_MEM_CMD_WR; req1_addr = A1;

    // single requester, data two cycles after the command
    sel = 0;
    do_reset();
    drive(1, 0, 1, NR, 32'h0);          push_ack(0);
    drive(0, 0, 0, NR, 32'h0);
    drive(0, 0, 0, OK, 32'hDEADBEEF);   push_resp(0, OK, 32'hDEADBEEF);
    drive(0, 0, 0, NR, 32'h0);

    // round-robin back-to-back, no bubble
    do_reset();
    drive(1, 1, 1, NR, 32'h0);          push_ack(0);
    drive(1, 1, 1, OK, 32'hA0A0_0000);  push_ack(1); push_resp(0, OK, 32'hA0A0_0000);
    drive(1, 1, 1, OK, 32'hA1A1_0001);  push_ack(0); push_resp(1, OK, 32'hA1A1_0001);
    drive(1, 1, 1, OK, 32'hA2A2_0002);  push_ack(1); push_resp(0, OK, 32'hA2A2_0002);
    drive(0, 0, 0, OK, 32'hA3A3_0003);  push_resp(1, OK, 32'hA3A3_0003);
    drive(0, 0, 0, NR, 32'h0);

    // fixed priority: port 0 takes all four
    sel = 1;
    do_reset();
    drive(1, 1, 1, NR, 32'h0);          push_ack(0);
    drive(1, 1, 1, OK, 32'hF000_0000);  push_ack(0); push_resp(0, OK, 32'hF000_0000);
    drive(1, 1, 1, OK, 32'hF000_0001);  push_ack(0); push_resp(0, OK, 32'hF000_0001);
    drive(1, 1, 1, OK, 32'hF000_0002);  push_ack(0); push_resp(0, OK, 32'hF000_0002);
    drive(0, 0, 0, OK, 32'hF000_0003);  push_resp(0, OK, 32'hF000_0003);
    drive(0, 0, 0, NR, 32'h0);

    // error response: no grant that cycle, port 1 granted next
    sel = 0;
    do_reset();
    drive(1, 0, 1, NR, 32'h0);          push_ack(0);
    drive(0, 1, 1, NR, 32'h0);
    drive(0, 1, 1, ER, 32'h0BAD_F00D);  push_resp(0, ER, 32'h0BAD_F00D);
    drive(0, 1, 1, NR, 32'h0);          push_ack(1);
    drive(0, 0, 0, OK, 32'h1111_2222);  push_resp(1, OK, 32'h1111_2222);
    drive(0, 0, 0, NR, 32'h0);

    // reset mid-transaction, late response ignored
    do_reset();
    drive(1, 0, 1, NR, 32'h0);          push_ack(0);
    drive(0, 0, 0, NR, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0; req0_req = 1'b1; req1_req = 1'b1; mem_req_ack = 1'b1;
    mem_resp = OK; mem_rdata = 32'h55AA_55AA; cyc_n++;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1; req0_req = 1'b0; req1_req = 1'b0; mem_req_ack = 1'b0;
    mem_resp = OK; mem_rdata = 32'h55AA_55AA; cyc_n++;
    #1;
    check_reset_vals();
    drive(0, 0, 0, NR, 32'h0);

    // selection on port 1 holds through 3 unacked cycles while port 0 rises
    do_reset();
    drive(0, 1, 0, NR, 32'h0);
    drive(1, 1, 0, NR, 32'h0);
    #1; chk("hold_req_c1", {31'd0, mem_req_d[0]}, 32'd1); chk("hold_addr_c1", mem_addr_d[0], A1);
    drive(1, 1, 0, NR, 32'h0);
    #1; chk("hold_req_c2", {31'd0, mem_req_d[0]}, 32'd1); chk("hold_addr_c2", mem_addr_d[0], A1);
    drive(1, 1, 1, NR, 32'h0);          push_ack(1);
    drive(1, 0, 1, OK, 32'h0000_0077);  push_ack(0); push_resp(1, OK, 32'h0000_0077);
    drive(0, 0, 0, OK, 32'h0000_0088);  push_resp(0, OK, 32'h0000_0088);
    drive(0, 0, 0, NR, 32'h0);
    drive(0, 0, 0, NR, 32'h0);

    @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
